// File: rtl/if_id_branch_unit.sv
// rtl/if_id_branch_unit.sv - IF/ID pipeline register with decode-stage branch resolution
// Hazard detection, branch redirect and saturating stall/flush debug counters.
module if_id_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] curr_pc_f,
  input  logic [15:0] curr_instr,
  input  logic [2:0]  flags,
  input  logic [15:0] rs_data,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic        ex_flag_write,
  input  logic [3:0]  ex_rd,
  input  logic        mem_reg_write,
  input  logic [3:0]  mem_rd,
  output logic [15:0] instr_d,
  output logic [15:0] pc_d,
  output logic        valid_d,
  output logic        halt_d,
  output logic        stall_de,
  output logic        branch_en,
  output logic [15:0] branch_pc,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [3:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        use_a;
  logic        use_b;
  logic        is_b;
  logic        is_br;
  logic        cond;
  logic        load_use;
  logic        br_reg;
  logic        br_flag;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic [15:0] b_offset;

  assign op     = instr_d[15:12];
  assign ra     = instr_d[7:4];
  assign is_b   = (op == 4'hC);
  assign is_br  = (op == 4'hD);
  assign flag_n = flags[2];
  assign flag_z = flags[1];
  assign flag_v = flags[0];

  // Second source sits in [3:0] for ALU ops and in [11:8] for stores/9.
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    rb    = instr_d[3:0];
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        use_a = 1'b1;
        use_b = 1'b1;
      end
      4'h4, 4'h5, 4'h6, 4'h8, 4'hD: use_a = 1'b1;
      4'h9: begin
        use_a = 1'b1;
        use_b = 1'b1;
        rb    = instr_d[11:8];
      end
      4'hA, 4'hB: begin
        use_b = 1'b1;
        rb    = instr_d[11:8];
      end
      default: ;
    endcase
  end

  assign load_use = ex_mem_read &
                    ((use_a & (ra != 4'd0) & (ex_rd == ra)) |
                     (use_b & (rb != 4'd0) & (ex_rd == rb)));
  assign br_reg   = is_br & (ra != 4'd0) &
                    ((ex_reg_write & (ex_rd == ra)) | (mem_reg_write & (mem_rd == ra)));
  assign br_flag  = (is_b | is_br) & ex_flag_write;
  assign stall_de = valid_d & (load_use | br_reg | br_flag);

  always_comb begin
    cond = 1'b1;
    case (instr_d[11:9])
      3'b000:  cond = ~flag_z;
      3'b001:  cond = flag_z;
      3'b010:  cond = ~flag_z & ~flag_n;
      3'b011:  cond = flag_n;
      3'b100:  cond = flag_z | ~flag_n;
      3'b101:  cond = flag_n | flag_z;
      3'b110:  cond = flag_v;
      default: cond = 1'b1;
    endcase
  end

  assign branch_en = valid_d & ~stall_de & (is_b | is_br) & cond;
  assign b_offset  = {{6{instr_d[8]}}, instr_d[8:0], 1'b0};
  assign branch_pc = is_b ? (pc_d + b_offset) : (is_br ? rs_data : pc_d);
  assign halt_d    = valid_d & (op == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d <= 16'h0000;
      pc_d    <= 16'h0000;
      valid_d <= 1'b0;
    end else if (stall_de) begin
      instr_d <= instr_d;
    end else if (branch_en) begin
      instr_d <= 16'h0000;
      pc_d    <= curr_pc_f;
      valid_d <= 1'b0;
    end else begin
      instr_d <= curr_instr;
      pc_d    <= curr_pc_f;
      valid_d <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (stall_de && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (branch_en && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_id_branch_unit.sv
// tb/tb_if_id_branch_unit.sv - self-checking bench for if_id_branch_unit
module tb_if_id_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] curr_pc_f, curr_instr, rs_data;
  logic [2:0]  flags;
  logic        ex_mem_read, ex_reg_write, ex_flag_write, mem_reg_write;
  logic [3:0]  ex_rd, mem_rd;
  logic [15:0] instr_d, pc_d, branch_pc, stall_cnt, flush_cnt;
  logic        valid_d, halt_d, stall_de, branch_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_instr, m_pc;
  logic        m_valid;
  int          m_sc, m_fc;

  if_id_branch_unit dut (
    .clk(clk), .rst(rst), .curr_pc_f(curr_pc_f), .curr_instr(curr_instr),
    .flags(flags), .rs_data(rs_data), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_flag_write(ex_flag_write), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .instr_d(instr_d),
    .pc_d(pc_d), .valid_d(valid_d), .halt_d(halt_d), .stall_de(stall_de),
    .branch_en(branch_en), .branch_pc(branch_pc), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] src_mask(input logic [15:0] ins);
    logic [15:0] m;
    m = 16'h0;
    case (ins[15:12])
      0, 1, 2, 3, 7: begin m[ins[7:4]] = 1'b1; m[ins[3:0]] = 1'b1; end
      4, 5, 6, 8, 13: m[ins[7:4]] = 1'b1;
      9: begin m[ins[7:4]] = 1'b1; m[ins[11:8]] = 1'b1; end
      10, 11: m[ins[11:8]] = 1'b1;
      default: ;
    endcase
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic bit m_stall();
    logic [15:0] mask;
    bit lu, brr, brf;
    int op;
    mask = src_mask(m_instr);
    op   = int'(m_instr[15:12]);
    lu   = ex_mem_read && mask[ex_rd];
    brr  = (op == 13) && (m_instr[7:4] != 0) &&
           ((ex_reg_write && ex_rd == m_instr[7:4]) || (mem_reg_write && mem_rd == m_instr[7:4]));
    brf  = (op == 12 || op == 13) && ex_flag_write;
    return m_valid && (lu || brr || brf);
  endfunction

  function automatic bit cond_true(input logic [2:0] c);
    bit n, z, v;
    n = flags[2]; z = flags[1]; v = flags[0];
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_branch();
    int op;
    op = int'(m_instr[15:12]);
    return m_valid && !m_stall() && (op == 12 || op == 13) && cond_true(m_instr[11:9]);
  endfunction

  function automatic logic [15:0] m_target();
    int off, pc, t;
    if (m_instr[15:12] == 4'hC) begin
      off = int'(m_instr[8:0]);
      if (off > 255) off = off - 512;
      pc = int'(m_pc);
      t  = (pc + 2 * off + 131072) % 65536;
      return t[15:0];
    end
    if (m_instr[15:12] == 4'hD) return rs_data;
    return m_pc;
  endfunction

  task automatic tick();
    bit es, eb;
    es = m_stall();
    eb = m_branch();
    if (rst) begin
      m_instr = 16'h0; m_pc = 16'h0; m_valid = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (!es) begin
        if (eb) begin m_instr = 16'h0; m_valid = 1'b0; m_pc = curr_pc_f; end
        else begin m_instr = curr_instr; m_pc = curr_pc_f; m_valid = 1'b1; end
      end
      if (es && m_sc < 65535) m_sc++;
      if (eb && m_fc < 65535) m_fc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    ex_mem_read = 0; ex_reg_write = 0; ex_flag_write = 0; mem_reg_write = 0;
    ex_rd = 0; mem_rd = 0;
  endtask

  task automatic load(input logic [15:0] ins, input logic [15:0] pc);
    clear_hazards();
    curr_instr = 16'h0000; curr_pc_f = pc - 16'd2;
    tick();
    curr_instr = ins; curr_pc_f = pc;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; curr_instr = 16'h1123; curr_pc_f = 16'h0002; flags = 0; rs_data = 0;
    clear_hazards();
    tick(); tick();
    n_checks += 7;
    if (instr_d !== 16'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0000", instr_d); end
    if (pc_d !== 16'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc_d); end
    if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_d); end
    if (stall_de !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_de); end
    if (branch_en !== 1'b0) begin n_fail++; $display("FAIL reset_branch got %b want 0", branch_en); end
    if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt got %h want 0000", stall_cnt); end
    if (flush_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_flush_cnt got %h want 0000", flush_cnt); end
  endtask

  task automatic test_pipeline();
    rst = 0; curr_instr = 16'h1123; curr_pc_f = 16'h0002;
    tick();
    n_checks += 4;
    if (instr_d !== 16'h1123) begin n_fail++; $display("FAIL pipe_instr got %h want 1123", instr_d); end
    if (pc_d !== 16'h0002) begin n_fail++; $display("FAIL pipe_pc got %h want 0002", pc_d); end
    if (valid_d !== 1'b1) begin n_fail++; $display("FAIL pipe_valid got %b want 1", valid_d); end
    if (halt_d !== 1'b0) begin n_fail++; $display("FAIL pipe_halt got %b want 0", halt_d); end
  endtask

  task automatic test_branch_b();
    flags = 3'b010;
    load(16'hC204, 16'h0010);
    curr_instr = 16'h1123; curr_pc_f = 16'h0012;
    #1;
    n_checks += 2;
    if (branch_en !== 1'b1) begin n_fail++; $display("FAIL b_taken_en got %b want 1", branch_en); end
    if (branch_pc !== 16'h0018) begin n_fail++; $display("FAIL b_taken_pc got %h want 0018", branch_pc); end
    tick();
    n_checks += 4;
    if (valid_d !== 1'b0) begin n_fail++; $display("FAIL b_flush_valid got %b want 0", valid_d); end
    if (instr_d !== 16'h0) begin n_fail++; $display("FAIL b_flush_instr got %h want 0000", instr_d); end
    if (pc_d !== 16'h0012) begin n_fail++; $display("FAIL b_flush_pc got %h want 0012", pc_d); end
    if (flush_cnt !== 16'h0001) begin n_fail++; $display("FAIL b_flush_cnt got %h want 0001", flush_cnt); end
    flags = 3'b000;
    load(16'hC204, 16'h0010);
    n_checks += 1;
    if (branch_en !== 1'b0) begin n_fail++; $display("FAIL b_not_taken got %b want 0", branch_en); end
    load(16'hCFFF, 16'h0000);
    n_checks += 2;
    if (branch_pc !== 16'hFFFE) begin n_fail++; $display("FAIL b_neg_pc got %h want FFFE", branch_pc); end
    if (branch_en !== 1'b1) begin n_fail++; $display("FAIL b_neg_en got %b want 1", branch_en); end
    tick();
  endtask

  task automatic test_load_use();
    load(16'h0435, 16'h0040);
    ex_mem_read = 1; ex_rd = 4'd3; curr_instr = 16'h1111;
    #1;
    n_checks += 1;
    if (stall_de !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall_de); end
    tick();
    n_checks += 2;
    if (instr_d !== 16'h0435) begin n_fail++; $display("FAIL lu_hold got %h want 0435", instr_d); end
    if (stall_cnt !== m_sc[15:0] || m_sc == 0) begin n_fail++; $display("FAIL lu_stall_cnt got %h want %h", stall_cnt, m_sc[15:0]); end
    ex_rd = 4'd0;
    #1;
    n_checks += 1;
    if (stall_de !== 1'b0) begin n_fail++; $display("FAIL lu_r0 got %b want 0", stall_de); end
    tick();
  endtask

  task automatic test_br_hazards();
    flags = 0; rs_data = 16'h1234;
    load(16'hDE30, 16'h0080);
    ex_reg_write = 1; ex_rd = 4'd3;
    #1;
    n_checks += 2;
    if (stall_de !== 1'b1) begin n_fail++; $display("FAIL br_reg_stall got %b want 1", stall_de); end
    if (branch_en !== 1'b0) begin n_fail++; $display("FAIL br_reg_en got %b want 0", branch_en); end
    tick();
    ex_reg_write = 0; ex_rd = 0; ex_flag_write = 1;
    #1;
    n_checks += 2;
    if (stall_de !== 1'b1) begin n_fail++; $display("FAIL br_flag_stall got %b want 1", stall_de); end
    if (branch_en !== 1'b0) begin n_fail++; $display("FAIL br_flag_en got %b want 0", branch_en); end
    tick();
    clear_hazards();
    #1;
    n_checks += 3;
    if (stall_de !== 1'b0) begin n_fail++; $display("FAIL br_clear_stall got %b want 0", stall_de); end
    if (branch_en !== 1'b1) begin n_fail++; $display("FAIL br_clear_en got %b want 1", branch_en); end
    if (branch_pc !== 16'h1234) begin n_fail++; $display("FAIL br_clear_pc got %h want 1234", branch_pc); end
    tick();
  endtask

  task automatic test_halt();
    load(16'hF000, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      n_checks += 2;
      if (halt_d !== 1'b1) begin n_fail++; $display("FAIL halt_d cycle %0d got %b want 1", i, halt_d); end
      if (instr_d !== 16'hF000) begin n_fail++; $display("FAIL halt_instr cycle %0d got %h want F000", i, instr_d); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      op = ($urandom_range(0, 2) == 0) ? 4'(12 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      curr_instr = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      if (op >= 4'hC) curr_instr[11:0] = 12'($urandom);
      curr_pc_f     = 16'($urandom);
      flags         = 3'($urandom);
      rs_data       = 16'($urandom);
      ex_mem_read   = ($urandom_range(0, 3) == 0);
      ex_reg_write  = ($urandom_range(0, 2) == 0);
      ex_flag_write = ($urandom_range(0, 4) == 0);
      mem_reg_write = ($urandom_range(0, 2) == 0);
      ex_rd         = 4'($urandom_range(0, 3));
      mem_rd        = 4'($urandom_range(0, 3));
      #1;
      n_checks += 9;
      if (instr_d !== m_instr) begin n_fail++; $display("FAIL rnd_instr %0d got %h want %h", i, instr_d, m_instr); end
      if (pc_d !== m_pc) begin n_fail++; $display("FAIL rnd_pc %0d got %h want %h", i, pc_d, m_pc); end
      if (valid_d !== m_valid) begin n_fail++; $display("FAIL rnd_valid %0d got %b want %b", i, valid_d, m_valid); end
      if (halt_d !== (m_valid && m_instr[15:12] == 4'hF)) begin n_fail++; $display("FAIL rnd_halt %0d got %b", i, halt_d); end
      if (stall_de !== m_stall()) begin n_fail++; $display("FAIL rnd_stall %0d got %b want %b", i, stall_de, m_stall()); end
      if (branch_en !== m_branch()) begin n_fail++; $display("FAIL rnd_branch %0d got %b want %b", i, branch_en, m_branch()); end
      if (branch_pc !== m_target()) begin n_fail++; $display("FAIL rnd_target %0d got %h want %h", i, branch_pc, m_target()); end
      if (stall_cnt !== m_sc[15:0]) begin n_fail++; $display("FAIL rnd_stall_cnt %0d got %h want %h", i, stall_cnt, m_sc[15:0]); end
      if (flush_cnt !== m_fc[15:0]) begin n_fail++; $display("FAIL rnd_flush_cnt %0d got %h want %h", i, flush_cnt, m_fc[15:0]); end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_saturation();
    rst = 0;
    load(16'h0435, 16'h0200);
    ex_mem_read = 1; ex_rd = 4'd5;
    for (int i = 0; i < 65540; i++) tick();
    n_checks += 3;
    if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall_cnt got %h want FFFF", stall_cnt); end
    if (instr_d !== 16'h0435) begin n_fail++; $display("FAIL sat_hold got %h want 0435", instr_d); end
    if (stall_de !== 1'b1) begin n_fail++; $display("FAIL sat_stall got %b want 1", stall_de); end
    rst = 1;
    tick();
    n_checks += 8;
    if (instr_d !== 16'h0) begin n_fail++; $display("FAIL rst_mid_instr got %h want 0000", instr_d); end
    if (pc_d !== 16'h0) begin n_fail++; $display("FAIL rst_mid_pc got %h want 0000", pc_d); end
    if (valid_d !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", valid_d); end
    if (halt_d !== 1'b0) begin n_fail++; $display("FAIL rst_mid_halt got %b want 0", halt_d); end
    if (stall_de !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %b want 0", stall_de); end
    if (branch_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_branch got %b want 0", branch_en); end
    if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_mid_stall_cnt got %h want 0000", stall_cnt); end
    if (flush_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_mid_flush_cnt got %h want 0000", flush_cnt); end
    rst = 0;
  endtask

  initial begin
    m_instr = 16'h0; m_pc = 16'h0; m_valid = 1'b0; m_sc = 0; m_fc = 0;
    test_reset();
    test_pipeline();
    test_branch_b();
    test_load_use();
    test_br_hazards();
    test_halt();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_branch_unit.md
# if_id_branch_unit

Decode-side neighbour of the fetch stage. Latches fetched instruction and PC+2 into the IF/ID pipeline register and resolves B/BR branches in decode. Detects load-use, branch-operand and branch-flag hazards, driving `stall_de`, `branch_en` and `branch_pc` back to fetch. Keeps saturating stall/flush event counters for debug.

## Interface
Parameters:
- none (16-bit datapath, 4-bit register IDs fixed by ISA)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- curr_pc_f  in  16  PC+2 of the instruction in fetch
- curr_instr  in  16  instruction in fetch
- flags  in  3  flag register {N,Z,V}
- rs_data  in  16  register-file read of instr_d[7:4] (BR target)
- ex_mem_read  in  1  EX-stage instruction is LW
- ex_reg_write  in  1  EX-stage instruction writes a register
- ex_flag_write  in  1  EX-stage instruction updates flags
- ex_rd  in  4  EX-stage destination register
- mem_reg_write  in  1  MEM-stage instruction writes a register
- mem_rd  in  4  MEM-stage destination register
- instr_d  out  16  IF/ID instruction
- pc_d  out  16  IF/ID PC+2
- valid_d  out  1  IF/ID holds a real instruction
- halt_d  out  1  valid_d & instr_d[15:12]==4'hF
- stall_de  out  1  hold PC and IF/ID this cycle
- branch_en  out  1  redirect fetch to branch_pc
- branch_pc  out  16  redirect target
- stall_cnt  out  16  cycles with stall_de=1, saturating
- flush_cnt  out  16  cycles with branch_en=1, saturating

## Operation
- Source registers of instr_d (op = instr_d[15:12]):
  - op 0,1,2,3,7: [7:4] and [3:0]
  - op 4,5,6: [7:4] only
  - op 8: [7:4]
  - op 9: [7:4] and [11:8]
  - op A,B: [11:8]
  - op D: [7:4]
  - op C,E,F: none
- R0 never a hazard: any match with register 0 is ignored.
- stall_de = valid_d & (load_use | br_reg | br_flag):
  - load_use: ex_mem_read & ex_rd matches any source register.
  - br_reg: op D & ((ex_reg_write & ex_rd==[7:4]) | (mem_reg_write & mem_rd==[7:4])).
  - br_flag: op C or D & ex_flag_write.
- Condition ccc = instr_d[11:9]:
  - 000 Z=0
  - 001 Z=1
  - 010 Z=0&N=0
  - 011 N=1
  - 100 Z=1|(Z=0&N=0)
  - 101 N=1|Z=1
  - 110 V=1
  - 111 always
- branch_en = valid_d & !stall_de & (op C or D) & cond true.
- branch_pc:
  - op C: pc_d + (sign-extended instr_d[8:0] << 1), 16-bit, wraps modulo 2^16.
  - op D: rs_data.
  - Otherwise: don't-care, held at pc_d.
- IF/ID update priority at each edge:
  1. rst: instr_d=0000, pc_d=0000, valid_d=0.
  2. stall_de: hold all.
  3. branch_en (flush): instr_d=0000, valid_d=0, pc_d=curr_pc_f.
  4. Otherwise: load curr_instr, curr_pc_f, valid_d=1.
- Halt: fetch holds PC on HLT. IF/ID relatches the same HLT each cycle; halt_d stays 1 and is stable.
- Counters:
  - stall_cnt increments when stall_de=1; flush_cnt increments when branch_en=1.
  - Both saturate at FFFF. rst clears both.

## Timing
- Reset values: instr_d=0000, pc_d=0000, valid_d=0, halt_d=0, stall_de=0, branch_en=0, counters 0.
- stall_de, branch_en and branch_pc are combinational from registered state plus inputs, valid in the same cycle. Fetch samples them at the next edge.
- Fetch-to-decode latency: 1 cycle.
- Branch penalty: 1 bubble (wrong-path fetch squashed at the resolving edge).
- Stall and branch in the same cycle: stall wins; the branch resolves in the first non-stalled cycle.
- rst asserted mid-stall or mid-branch: all state returns to reset values at that edge. No redirect is pending afterwards.
- Hazard inputs change only at edges; stall lasts exactly as long as the hazard condition holds.

## Test plan
- Reset: hold rst 2 cycles with curr_instr=1123 -> instr_d=0000, pc_d=0000, valid_d=0, stall_de=0, branch_en=0, counters 0.
- Pipeline: curr_instr=1123, curr_pc_f=0002, one edge -> instr_d=1123, pc_d=0002, valid_d=1, halt_d=0.
- B taken/not taken/negative offset:
  - instr_d=C204, pc_d=0010, Z=1 -> branch_en=1, branch_pc=0018. Next edge: valid_d=0, instr_d=0000, flush_cnt=1.
  - Same with Z=0 -> branch_en=0.
  - instr_d=CFFF, pc_d=0000 -> branch_pc=FFFE.
- Load-use: instr_d=0435, ex_mem_read=1, ex_rd=3 -> stall_de=1, instr_d held, stall_cnt increments. With ex_rd=0 -> stall_de=0.
- BR hazards: instr_d=DE30, rs_data=1234:
  - ex_reg_write=1, ex_rd=3 -> stall_de=1, branch_en=0.
  - Then ex_flag_write=1 only -> still stalled.
  - All clear -> branch_en=1, branch_pc=1234.
- HLT and saturation:
  - curr_instr=F000 held -> halt_d=1 stable over 5 cycles.
  - Force stall 65540 cycles -> stall_cnt=FFFF.
  - Assert rst mid-stall -> all outputs return to reset values next edge.
